// File: rtl/a5_wb_slave_if.sv
// Wishbone classic slave bus bundle for the A5/1 key/keystream register block.
// Signal names keep the Wishbone _i/_o suffixes as seen from the slave.
interface a5_wb_slave_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_dat_o;
   logic        wbs_ack_o;
   logic        wbs_err_o;

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_dat_o, wbs_ack_o, wbs_err_o
   );

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_dat_o, wbs_ack_o, wbs_err_o
   );
endinterface

// File: rtl/a5_wb_slave.sv
// Wishbone register window for an A5/1 core: key/frame registers, start pulse,
// and a DATA port that pops keystream words from a first-word-fall-through buffer.
module a5_wb_slave #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          TIMEOUT   = 64
) (
   input  logic                clk,
   input  logic                reset_n,
   a5_wb_slave_if.slave        wb,
   output logic [63:0]         key,
   output logic [21:0]         frame,
   output logic                buf_load,
   input  logic [31:0]         buf_data,
   input  logic                buf_empty,
   output logic                buf_rd_en
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_ERR} state_e;

   typedef enum logic [2:0] {
      REG_KEY_LO, REG_KEY_HI, REG_FRAME, REG_CTRL,
      REG_DATA, REG_COUNT, REG_RSVD6, REG_RSVD7
   } reg_e;

   state_e        r_state, w_next_state;
   logic [63:0]   r_key;
   logic [21:0]   r_frame;
   logic [31:0]   r_count;
   logic [31:0]   r_dat_o;
   logic [TW-1:0] r_timeout;
   logic          r_buf_load;

   logic          w_req, w_hit;
   reg_e          w_offset;
   logic [31:0]   w_rd_data;
   logic          w_ack, w_err, w_rd_en;
   logic          w_wr_capture, w_rd_capture, w_to_err, w_to_inc, w_to_clr;
   logic          w_unused_ok;

   assign w_req       = wb.wbs_cyc_i & wb.wbs_stb_i;
   assign w_hit       = w_req & (wb.wbs_adr_i[31:5] == BASE_ADDR[31:5]);
   assign w_offset    = reg_e'(wb.wbs_adr_i[4:2]);
   assign w_unused_ok = &{1'b0, wb.wbs_adr_i[1:0]};

   always_comb begin
      w_rd_data = '0;
      unique case (w_offset)
         REG_KEY_LO: w_rd_data = r_key[31:0];
         REG_KEY_HI: w_rd_data = r_key[63:32];
         REG_FRAME:  w_rd_data = {10'd0, r_frame};
         REG_CTRL:   w_rd_data = {31'd0, buf_empty};
         REG_COUNT:  w_rd_data = r_count;
         default:    w_rd_data = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   // NOTE: every output of this block gets a default first so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_ack        = 1'b0;
      w_err        = 1'b0;
      w_rd_en      = 1'b0;
      w_wr_capture = 1'b0;
      w_rd_capture = 1'b0;
      w_to_err     = 1'b0;
      w_to_inc     = 1'b0;
      w_to_clr     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_hit) begin
               if (!wb.wbs_we_i && w_offset == REG_DATA) begin
                  w_next_state = S_WAIT;
               end else begin
                  w_next_state = S_ACK;
                  w_wr_capture = wb.wbs_we_i;
                  w_rd_capture = !wb.wbs_we_i;
               end
            end
         end
         S_WAIT: begin
            // Master gave up: abandon silently, without popping.
            if (!w_req) begin
               w_next_state = S_IDLE;
               w_to_clr     = 1'b1;
            end else if (!buf_empty) begin
               w_rd_en      = 1'b1;
               w_to_clr     = 1'b1;
               w_next_state = S_ACK;
            end else if (r_timeout == TO_LAST) begin
               w_to_err     = 1'b1;
               w_to_clr     = 1'b1;
               w_next_state = S_ERR;
            end else begin
               w_to_inc     = 1'b1;
            end
         end
         S_ACK: begin
            w_ack        = 1'b1;
            w_next_state = S_IDLE;
         end
         S_ERR: begin
            w_err        = 1'b1;
            w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_key      <= '0;
         r_frame    <= '0;
         r_count    <= '0;
         r_dat_o    <= '0;
         r_timeout  <= '0;
         r_buf_load <= 1'b0;
      end else begin
         r_buf_load <= 1'b0;
         if (w_wr_capture) begin
            unique case (w_offset)
               REG_KEY_LO: begin
                  for (int b = 0; b < 4; b++)
                     if (wb.wbs_sel_i[b]) r_key[b*8 +: 8] <= wb.wbs_dat_i[b*8 +: 8];
               end
               REG_KEY_HI: begin
                  for (int b = 0; b < 4; b++)
                     if (wb.wbs_sel_i[b]) r_key[32 + b*8 +: 8] <= wb.wbs_dat_i[b*8 +: 8];
               end
               REG_FRAME: begin
                  if (wb.wbs_sel_i[0]) r_frame[7:0]   <= wb.wbs_dat_i[7:0];
                  if (wb.wbs_sel_i[1]) r_frame[15:8]  <= wb.wbs_dat_i[15:8];
                  if (wb.wbs_sel_i[2]) r_frame[21:16] <= wb.wbs_dat_i[21:16];
               end
               REG_CTRL: begin
                  if (wb.wbs_sel_i[0] && wb.wbs_dat_i[0]) begin
                     r_buf_load <= 1'b1;
                     r_count    <= '0;
                  end
               end
               default: ;
            endcase
         end
         if (w_rd_capture) r_dat_o <= w_rd_data;
         if (w_rd_en) begin
            r_dat_o <= buf_data;
            r_count <= r_count + 32'd1;
         end
         if (w_to_err) r_dat_o <= '0;
         if (w_to_clr)      r_timeout <= '0;
         else if (w_to_inc) r_timeout <= r_timeout + 1'b1;
      end
   end

   assign wb.wbs_dat_o = r_dat_o;
   assign wb.wbs_ack_o = w_ack;
   assign wb.wbs_err_o = w_err;
   assign key          = r_key;
   assign frame        = r_frame;
   assign buf_load     = r_buf_load;
   assign buf_rd_en    = w_rd_en;

endmodule

// File: tb/tb_a5_wb_slave.sv
// Directed self-checking bench for a5_wb_slave: register access, keystream pops,
// timeout error, aborted cycles and asynchronous reset.
module tb_a5_wb_slave;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [63:0] key;
   logic [21:0] frame;
   logic        buf_load, buf_rd_en, buf_empty;
   logic [31:0] buf_data;

   int          n_checks = 0;
   int          n_fail   = 0;

   logic [31:0] r_rdata;
   int          r_lat, r_n_rd, r_n_load;
   logic        r_got_ack, r_got_err, r_load_at_ack, r_tail, r_both;

   a5_wb_slave_if wb_if ();

   a5_wb_slave #(.BASE_ADDR(BASE), .TIMEOUT(64)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .wb        (wb_if),
      .key       (key),
      .frame     (frame),
      .buf_load  (buf_load),
      .buf_data  (buf_data),
      .buf_empty (buf_empty),
      .buf_rd_en (buf_rd_en)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("%s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One bus access; lat counts cycles after the strobe cycle until ack/err.
   task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input int release_at, input int max_cyc);
      @(posedge clk); #1;
      wb_if.wbs_cyc_i = 1'b1; wb_if.wbs_stb_i = 1'b1; wb_if.wbs_we_i = we;
      wb_if.wbs_adr_i = adr;  wb_if.wbs_dat_i = dat;  wb_if.wbs_sel_i = sel;
      r_lat = 0; r_n_rd = 0; r_n_load = 0;
      r_got_ack = 1'b0; r_got_err = 1'b0; r_load_at_ack = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         r_n_rd   += int'(buf_rd_en);
         r_n_load += int'(buf_load);
         if (wb_if.wbs_ack_o && wb_if.wbs_err_o) r_both = 1'b1;
         if (wb_if.wbs_ack_o || wb_if.wbs_err_o) begin
            r_got_ack = wb_if.wbs_ack_o; r_got_err = wb_if.wbs_err_o;
            r_rdata = wb_if.wbs_dat_o; r_load_at_ack = buf_load;
            break;
         end
         r_lat++;
         @(posedge clk); #1;
         if (r_lat == release_at) buf_empty = 1'b0;
      end
      @(posedge clk); #1;
      wb_if.wbs_cyc_i = 1'b0; wb_if.wbs_stb_i = 1'b0; wb_if.wbs_we_i = 1'b0;
      @(negedge clk);
      r_tail    = wb_if.wbs_ack_o | wb_if.wbs_err_o;
      r_n_rd   += int'(buf_rd_en);
      r_n_load += int'(buf_load);
   endtask

   task automatic wb_wr(input int off, input logic [31:0] dat, input logic [3:0] sel);
      wb_access(1'b1, BASE + 32'(off * 4), dat, sel, -1, 200);
   endtask

   task automatic wb_rd(input int off);
      wb_access(1'b0, BASE + 32'(off * 4), 32'h0, 4'hF, -1, 200);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0; buf_empty = 1'b1; buf_data = 32'h0; r_both = 1'b0;
      wb_if.wbs_cyc_i = 1'b0; wb_if.wbs_stb_i = 1'b0; wb_if.wbs_we_i = 1'b0;
      wb_if.wbs_sel_i = 4'h0; wb_if.wbs_adr_i = 32'h0; wb_if.wbs_dat_i = 32'h0;
      #1;
      check("rst_ack",  64'(wb_if.wbs_ack_o), 64'd0);
      check("rst_err",  64'(wb_if.wbs_err_o), 64'd0);
      check("rst_dat",  64'(wb_if.wbs_dat_o), 64'd0);
      check("rst_key",  key, 64'd0);
      check("rst_frm",  64'(frame), 64'd0);
      check("rst_load", 64'(buf_load), 64'd0);
      check("rst_rden", 64'(buf_rd_en), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Byte-enabled key writes and read-back
      wb_wr(0, 32'h1234_5678, 4'b0011);
      check("klo_ack", 64'(r_got_ack), 64'd1);
      check("klo_lat", 64'(r_lat), 64'd1);
      check("klo_tail", 64'(r_tail), 64'd0);
      check("klo_key", 64'(key[31:0]), 64'h0000_5678);
      wb_rd(0);
      check("klo_rd", 64'(r_rdata), 64'h0000_5678);
      check("klo_rdlat", 64'(r_lat), 64'd1);
      wb_wr(1, 32'hAABB_CCDD, 4'b1100);
      wb_wr(1, 32'h1122_3344, 4'b0001);
      check("khi_key", key, 64'hAABB_0044_0000_5678);

      // Frame masking and partial write
      wb_wr(2, 32'hFFFF_FFFF, 4'hF);
      check("frm_val", 64'(frame), 64'h3F_FFFF);
      wb_rd(2);
      check("frm_rd", 64'(r_rdata), 64'h003F_FFFF);
      wb_wr(2, 32'h0000_0000, 4'b0100);
      check("frm_part", 64'(frame), 64'h00_FFFF);
      check("dat_hold", 64'(wb_if.wbs_dat_o), 64'h003F_FFFF);

      // CTRL read reflects buf_empty
      wb_rd(3);
      check("ctrl_e1", 64'(r_rdata), 64'd1);
      buf_empty = 1'b0; buf_data = 32'hDEAD_BEEF;
      wb_rd(3);
      check("ctrl_e0", 64'(r_rdata), 64'd0);

      // DATA pop from a non-empty buffer
      wb_rd(4);
      check("pop_ack", 64'(r_got_ack), 64'd1);
      check("pop_lat", 64'(r_lat), 64'd2);
      check("pop_dat", 64'(r_rdata), 64'hDEAD_BEEF);
      check("pop_rd",  64'(r_n_rd), 64'd1);
      wb_rd(5);
      check("cnt_1", 64'(r_rdata), 64'd1);
      wb_wr(5, 32'h0000_FFFF, 4'hF);
      wb_wr(4, 32'h5555_5555, 4'hF);
      check("wr_noPop", 64'(r_n_rd), 64'd0);
      wb_rd(5);
      check("cnt_wrign", 64'(r_rdata), 64'd1);
      wb_rd(6);
      check("rsvd_rd", 64'(r_rdata), 64'd0);
      wb_rd(4);
      wb_rd(5);
      check("cnt_2", 64'(r_rdata), 64'd2);

      // Start pulse
      buf_empty = 1'b1;
      wb_wr(3, 32'h0000_0001, 4'b0010);
      check("ctrl_nosel", 64'(r_n_load), 64'd0);
      wb_wr(3, 32'h0000_0001, 4'b0001);
      check("load_cnt", 64'(r_n_load), 64'd1);
      check("load_ack", 64'(r_load_at_ack), 64'd1);
      check("load_key", key, 64'hAABB_0044_0000_5678);
      wb_rd(5);
      check("cnt_clr", 64'(r_rdata), 64'd0);

      // Timeout with the buffer held empty
      wb_rd(4);
      check("to_err", 64'(r_got_err), 64'd1);
      check("to_ack", 64'(r_got_ack), 64'd0);
      check("to_lat", 64'(r_lat), 64'd65);
      check("to_dat", 64'(r_rdata), 64'd0);
      check("to_rd",  64'(r_n_rd), 64'd0);
      check("to_tail", 64'(r_tail), 64'd0);

      // Buffer fills during the wait
      buf_data = 32'h0BAD_F00D;
      wb_access(1'b0, BASE + 32'h10, 32'h0, 4'hF, 10, 200);
      check("late_ack", 64'(r_got_ack), 64'd1);
      check("late_err", 64'(r_got_err), 64'd0);
      check("late_lat", 64'(r_lat), 64'd11);
      check("late_dat", 64'(r_rdata), 64'h0BAD_F00D);
      check("late_rd",  64'(r_n_rd), 64'd1);

      // Out-of-window access
      wb_access(1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, -1, 8);
      check("miss_resp", 64'({r_got_ack, r_got_err}), 64'd0);
      check("miss_key", key, 64'hAABB_0044_0000_5678);

      // Master drops cyc mid-wait; timeout must restart from zero
      buf_empty = 1'b1;
      @(posedge clk); #1;
      wb_if.wbs_cyc_i = 1'b1; wb_if.wbs_stb_i = 1'b1; wb_if.wbs_we_i = 1'b0;
      wb_if.wbs_adr_i = BASE + 32'h10;
      repeat (20) @(posedge clk);
      #1;
      wb_if.wbs_cyc_i = 1'b0; wb_if.wbs_stb_i = 1'b0;
      buf_empty = 1'b0;
      r_n_rd = 0; r_tail = 1'b0;
      repeat (5) begin
         @(negedge clk);
         r_n_rd += int'(buf_rd_en);
         r_tail |= wb_if.wbs_ack_o | wb_if.wbs_err_o;
      end
      check("drop_rd",   64'(r_n_rd), 64'd0);
      check("drop_resp", 64'(r_tail), 64'd0);
      buf_empty = 1'b1;
      wb_rd(4);
      check("drop_tolat", 64'(r_lat), 64'd65);

      // Asynchronous reset in the middle of a DATA read
      @(posedge clk); #1;
      wb_if.wbs_cyc_i = 1'b1; wb_if.wbs_stb_i = 1'b1; wb_if.wbs_adr_i = BASE + 32'h10;
      repeat (3) @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      check("arst_key",  key, 64'd0);
      check("arst_frm",  64'(frame), 64'd0);
      check("arst_dat",  64'(wb_if.wbs_dat_o), 64'd0);
      check("arst_resp", 64'({wb_if.wbs_ack_o, wb_if.wbs_err_o, buf_load}), 64'd0);
      buf_empty = 1'b0;
      @(negedge clk);
      check("arst_rden", 64'(buf_rd_en), 64'd0);
      wb_if.wbs_cyc_i = 1'b0; wb_if.wbs_stb_i = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      wb_rd(5);
      check("arst_cnt", 64'(r_rdata), 64'd0);
      wb_wr(0, 32'hCAFE_0001, 4'hF);
      check("post_lat", 64'(r_lat), 64'd1);
      check("post_key", key, 64'h0000_0000_CAFE_0001);
      buf_data = 32'h1357_9BDF;
      wb_rd(4);
      check("post_poplat", 64'(r_lat), 64'd2);
      check("post_popdat", 64'(r_rdata), 64'h1357_9BDF);
      check("ack_err_excl", 64'(r_both), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/a5_wb_slave.md
A5_WB_SLAVE -- requirements
Module: a5_wb_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, byte base address of the 32-byte register window.
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum wait cycles for a keystream word before a bus error.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic cycle, strobe and write enable.
REQ-006 wbs_sel_i  in  4  byte enables; wbs_adr_i  in  32  byte address; wbs_dat_i  in  32  write data.
REQ-007 wbs_dat_o  out  32  read data; wbs_ack_o  out  1  acknowledge; wbs_err_o  out  1  error.
REQ-008 key  out  64  A5/1 session key; frame  out  22  frame number; buf_load  out  1  single-cycle load/flush pulse.
REQ-009 buf_data  in  32  keystream word; buf_empty  in  1  no word available; buf_rd_en  out  1  pop strobe.
REQ-010 buf_data SHALL be treated as first-word fall-through: valid whenever buf_empty=0; one-cycle buf_rd_en pops exactly one word.

Function
REQ-011 Hit = cyc & stb & adr[31:5]==BASE_ADDR[31:5]; offset = adr[4:2]; misses SHALL produce no ack/err and no side effects.
REQ-012 Register map: 0 KEY_LO (key[31:0], RW), 1 KEY_HI (key[63:32], RW), 2 FRAME (bits 21:0, RW, 31:22 read 0), 3 CTRL (W bit0=start; R bit0=buf_empty), 4 DATA (R pops keystream; W ignored), 5 COUNT (R words popped since last start, 32-bit, wraps at 2^32; W ignored), 6-7 read 0, writes ignored.
REQ-013 KEY_LO/KEY_HI/FRAME writes SHALL honour wbs_sel_i per byte.
REQ-014 FSM states IDLE, WAIT, ACK, ERR; IDLE on hit: DATA read -> WAIT, any other access -> ACK, with the write or read capture performed in that transition cycle.
REQ-015 ACK state: wbs_ack_o=1 for exactly one cycle, then IDLE; ERR state: wbs_err_o=1 for exactly one cycle, then IDLE; ack and err never both high.
REQ-016 Register access latency: stb sampled at cycle N -> ack high in cycle N+1.
REQ-017 WAIT with buf_empty=0: buf_rd_en=1 combinationally that cycle, wbs_dat_o<=buf_data, COUNT+1, -> ACK (minimum DATA latency: ack at N+2).
REQ-018 WAIT with buf_empty=1: timeout counter increments; after TIMEOUT consecutive empty cycles -> ERR, wbs_dat_o<=0, no pop.
REQ-019 WAIT with cyc or stb dropped: -> IDLE, no pop, no ack/err, timeout counter cleared.
REQ-020 buf_rd_en SHALL be asserted only in WAIT with buf_empty=0 and cyc&stb=1; never otherwise.
REQ-021 CTRL write with sel[0]=1 and dat[0]=1: buf_load=1 in the ACK cycle only, COUNT<=0 same edge; key/frame registers unchanged.
REQ-022 wbs_dat_o SHALL hold its last value outside ACK/ERR; writes return no data change.
REQ-023 key and frame SHALL be driven directly from the registers and stay stable except on their own writes.

Reset
REQ-024 reset_n low SHALL asynchronously force: state IDLE, key=0, frame=0, COUNT=0, timeout counter=0, wbs_dat_o=0, wbs_ack_o=0, wbs_err_o=0, buf_load=0, buf_rd_en=0.
REQ-025 Reset mid-transaction SHALL abandon it with no ack, no pop; first access after release behaves per REQ-016/017.

Verification
REQ-026 Write KEY_LO=0x12345678 sel=4'b0011 after reset -> ack at N+1, key[31:0]=0x00005678, read-back 0x00005678.
REQ-027 Write FRAME=0xFFFFFFFF -> frame=22'h3FFFFF, FRAME read returns 0x003FFFFF.
REQ-028 CTRL write 0x1 -> single buf_load pulse coincident with ack; COUNT reads 0.
REQ-029 DATA read with buf_empty=0, buf_data=0xDEADBEEF -> one buf_rd_en pulse, ack at N+2, dat=0xDEADBEEF, COUNT=1.
REQ-030 DATA read with buf_empty held 1, TIMEOUT=64 -> err one cycle after 64 empty WAIT cycles, dat=0, no buf_rd_en; buf_empty falling at cycle 10 instead -> normal ack, no err.
REQ-031 Drop cyc during WAIT, then assert reset_n low mid-read -> no ack/err/pop in either case; all outputs at REQ-024 values.
